// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding and sizing constants for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmemState_t;
    localparam int CNT_W = 4;
    localparam int LANES = 4;
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: 2^ADDR_W x 32 RAM, four byte-lane write enables, registered read port.
//   clk, rst : clock, sync active-high reset (clears only the read register)
//   en       : perform the access on this edge
//   rdZero   : load 0 into rdata instead of the addressed word (writes, range errors)
//   wen      : byte-lane write enables
//   idx      : word index
//   wdata    : lane-aligned write data
//   rdata    : registered read data
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rdZero,
    input  logic [LANES-1:0]  wen,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W];

    // Kept reset-free so it maps onto a RAM macro.
    always_ff @(posedge clk)
        for (int i = 0; i < LANES; i++)
            if (en && wen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];

    always_ff @(posedge clk)
        if (rst) rdata <= '0;
        else if (en) rdata <= rdZero ? '0 : mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: M-stage load/store responder with WAIT_CYC wait states in front of dmem_bank.
//   clk, rst : clock, sync active-high reset
//   req      : access request (held stable while stall=1)
//   wen      : byte-lane write enables, 0 = read
//   addr     : byte address, word index = addr[ADDR_W+1:2]
//   wdata    : lane-aligned write data
//   rdata    : read data, valid in the done cycle
//   stall    : pipeline hold request
//   done     : one-cycle completion pulse
//   err      : out-of-range pulse with done (only with DMEM_RANGE_CHECK_EN defined)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err
);
    dmemState_t state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic [LANES-1:0]  wenQ, curWen;
    logic [ADDR_W-1:0] idxQ, curIdx;
    logic [31:0]       wdataQ, curWdata;
    logic              oorQ, oorIn, curOor, accept, enterResp, unusedAddr;

    assign accept = state == IDLE && req;

    always_comb begin
        nextState = state;
        if (accept) nextState = WAIT_CYC == 0 ? RESP : WAIT;
        else if (state == WAIT && cnt == CNT_W'(1)) nextState = RESP;
        else if (state == RESP) nextState = IDLE;
    end

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                cnt    <= CNT_W'(WAIT_CYC);
                wenQ   <= wen;
                idxQ   <= addr[ADDR_W+1:2];
                wdataQ <= wdata;
                oorQ   <= oorIn;
            end else if (state == WAIT) cnt <= cnt - 1'b1;
        end

    // With zero wait states the RAM edge is the acceptance edge, so the live inputs are used.
    assign curWen    = accept ? wen : wenQ;
    assign curIdx    = accept ? addr[ADDR_W+1:2] : idxQ;
    assign curWdata  = accept ? wdata : wdataQ;
    assign curOor    = accept ? oorIn : oorQ;
    assign enterResp = nextState == RESP && !rst;

    assign stall = !rst && (accept || state == WAIT);
    assign done  = state == RESP;

`ifdef DMEM_RANGE_CHECK_EN
    assign oorIn = |addr[31:ADDR_W+2];
    assign err   = state == RESP && oorQ;
`else
    assign oorIn = 1'b0;
    assign err   = 1'b0;
`endif
    assign unusedAddr = ^{addr[31:ADDR_W+2], addr[1:0]};

    dmem_bank #(.ADDR_W(ADDR_W)) bank (
        .clk    (clk),
        .rst    (rst),
        .en     (enterResp),
        .rdZero (curOor || |curWen),
        .wen    (curOor ? 4'b0000 : curWen),
        .idx    (curIdx),
        .wdata  (curWdata),
        .rdata  (rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder (WAIT_CYC=2 and WAIT_CYC=0 instances).
module tb_dmem_responder;
    localparam int AW = 12;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 0, rst = 1, req = 0, sel = 0;
    logic [3:0]  wen = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [31:0] rdata0, rdata1;
    logic        stall0, stall1, done0, done1, err0, err1;
    int tests = 0, fails = 0;
    logic [31:0] mdl [int];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(AW), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst), .req(req && !sel), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .stall(stall0), .done(done0), .err(err0));

    dmem_responder #(.ADDR_W(AW), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req(req && sel), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .stall(stall1), .done(done1), .err(err1));

    function automatic bit oorOf(logic [31:0] a);
        return RC && (a[31:AW+2] != 0);
    endfunction

    function automatic void mwrite(logic [31:0] a, logic [3:0] w, logic [31:0] d);
        int i = int'(a[AW+1:2]);
        logic [31:0] v = mdl.exists(i) ? mdl[i] : 32'h0;
        if (oorOf(a)) return;
        for (int l = 0; l < 4; l++) if (w[l]) v[8*l +: 8] = d[8*l +: 8];
        mdl[i] = v;
    endfunction

    function automatic logic [31:0] mread(logic [31:0] a);
        return oorOf(a) ? 32'h0 : mdl[int'(a[AW+1:2])];
    endfunction

    // Drives one access on the instance picked by sel and reports what was observed.
    task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int stalls, output logic ds,
                          output logic [31:0] rd, output logic er);
        lat = -1; stalls = 0; ds = 1; rd = 'x; er = 'x;
        @(negedge clk);
        req = 1; wen = w; addr = a; wdata = d;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (sel ? done1 : done0) begin
                lat = c; ds = sel ? stall1 : stall0;
                rd = sel ? rdata1 : rdata0; er = sel ? err1 : err0;
                break;
            end
            if (sel ? stall1 : stall0) stalls++;
        end
        req = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req = 1;
        #1;
        tests++; if (stall0 !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall0); end
        @(posedge clk);
        #1;
        tests++; if ({done0, err0, done1, err1} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b want 0000", {done0, err0, done1, err1}); end
        tests++; if (rdata0 !== 0 || rdata1 !== 0) begin fails++; $display("FAIL reset_rdata: got %h/%h want 0", rdata0, rdata1); end
        req = 0;
        rst = 0;
    endtask

    task automatic test_write_read;
        int lat, st; logic ds, er; logic [31:0] rd;
        access(4'b1111, 32'h10, 32'hDEADBEEF, lat, st, ds, rd, er);
        mwrite(32'h10, 4'b1111, 32'hDEADBEEF);
        tests++; if (lat !== 3 || st !== 3 || ds !== 1'b0) begin fails++; $display("FAIL write_timing: got lat=%0d stalls=%0d dstall=%b want 3 3 0", lat, st, ds); end
        tests++; if (rd !== 0 || er !== 1'b0) begin fails++; $display("FAIL write_rdata: got %h err=%b want 0 0", rd, er); end
        access(4'b0000, 32'h10, 32'h0, lat, st, ds, rd, er);
        tests++; if (rd !== 32'hDEADBEEF || lat !== 3) begin fails++; $display("FAIL read_full: got %h lat=%0d want deadbeef 3", rd, lat); end
        access(4'b0010, 32'h10, 32'h0000AA00, lat, st, ds, rd, er);
        mwrite(32'h10, 4'b0010, 32'h0000AA00);
        access(4'b0000, 32'h10, 32'h0, lat, st, ds, rd, er);
        tests++; if (rd !== 32'hDEADAAEF) begin fails++; $display("FAIL read_lane: got %h want deadaaef", rd); end
        access(4'b0000, 32'h13, 32'h0, lat, st, ds, rd, er);
        tests++; if (rd !== 32'hDEADAAEF) begin fails++; $display("FAIL read_unaligned: got %h want deadaaef", rd); end
    endtask

    task automatic test_zero_wait;
        int lat, st; logic ds, er; logic [31:0] rd;
        sel = 1;
        access(4'b1111, 32'h10, 32'hDEADBEEF, lat, st, ds, rd, er);
        tests++; if (lat !== 1 || st !== 1 || ds !== 1'b0) begin fails++; $display("FAIL zw_write_timing: got lat=%0d stalls=%0d want 1 1", lat, st); end
        access(4'b0000, 32'h10, 32'h0, lat, st, ds, rd, er);
        tests++; if (rd !== 32'hDEADBEEF || lat !== 1 || st !== 1) begin fails++; $display("FAIL zw_read: got %h lat=%0d stalls=%0d want deadbeef 1 1", rd, lat, st); end
        sel = 0;
    endtask

    task automatic test_reset_mid;
        int lat, st; logic ds, er; logic [31:0] rd;
        bit saw;
        access(4'b1111, 32'h20, 32'h0, lat, st, ds, rd, er);
        mwrite(32'h20, 4'b1111, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req = 1; wen = 4'b1111; addr = 32'h20; wdata = 32'h12345678;
            repeat (k) @(negedge clk);
            rst = 1;
            #1;
            tests++; if (stall0 !== 1'b0) begin fails++; $display("FAIL rstmid_stall k=%0d: got %b want 0", k, stall0); end
            @(posedge clk);
            #1;
            rst = 0; req = 0;
            tests++; if ({done0, err0} !== 2'b0 || rdata0 !== 0) begin fails++; $display("FAIL rstmid_out k=%0d: got done=%b err=%b rdata=%h want 0", k, done0, err0, rdata0); end
            saw = 0;
            repeat (6) begin @(negedge clk); #1; if (done0) saw = 1; end
            tests++; if (saw) begin fails++; $display("FAIL rstmid_done k=%0d: got done pulse want none", k); end
            access(4'b0000, 32'h20, 32'h0, lat, st, ds, rd, er);
            tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rstmid_ram k=%0d: got %h want 0", k, rd); end
        end
    endtask

    task automatic test_range;
        int lat, st; logic ds, er; logic [31:0] rd;
        access(4'b1111, 32'h0, 32'h11111111, lat, st, ds, rd, er);
        mwrite(32'h0, 4'b1111, 32'h11111111);
        access(4'b1111, 32'h0001_0000, 32'hCAFEF00D, lat, st, ds, rd, er);
        mwrite(32'h0001_0000, 4'b1111, 32'hCAFEF00D);
        tests++; if (er !== RC || lat !== 3) begin fails++; $display("FAIL range_write_err: got err=%b lat=%0d want %b 3", er, lat, RC); end
        access(4'b0000, 32'h0, 32'h0, lat, st, ds, rd, er);
        tests++; if (rd !== (RC ? 32'h11111111 : 32'hCAFEF00D) || er !== 1'b0) begin fails++; $display("FAIL range_word0: got %h err=%b want %h 0", rd, er, RC ? 32'h11111111 : 32'hCAFEF00D); end
        access(4'b0000, 32'h0001_0000, 32'h0, lat, st, ds, rd, er);
        tests++; if (rd !== (RC ? 32'h0 : 32'hCAFEF00D) || er !== RC) begin fails++; $display("FAIL range_read: got %h err=%b want %h %b", rd, er, RC ? 32'h0 : 32'hCAFEF00D, RC); end
    endtask

    task automatic test_back_to_back;
        int lat, st; logic ds, er; logic [31:0] rd, r1, r2;
        int d1, d2;
        logic [15:0] stallBits;
        access(4'b1111, 32'h14, 32'h01020304, lat, st, ds, rd, er);
        mwrite(32'h14, 4'b1111, 32'h01020304);
        d1 = -1; d2 = -1; r1 = 'x; r2 = 'x; stallBits = '0;
        @(negedge clk);
        req = 1; wen = 4'b0000; addr = 32'h10; wdata = 0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            stallBits[c] = stall0;
            if (done0) begin
                if (d1 < 0) begin d1 = c; r1 = rdata0; addr = 32'h14; end
                else begin d2 = c; r2 = rdata0; break; end
            end
        end
        req = 0;
        tests++; if (d1 !== 3 || d2 !== 7) begin fails++; $display("FAIL b2b_done: got %0d,%0d want 3,7", d1, d2); end
        tests++; if (stallBits[7:0] !== 8'b0111_0111) begin fails++; $display("FAIL b2b_stall: got %b want 01110111", stallBits[7:0]); end
        tests++; if (r1 !== mread(32'h10) || r2 !== 32'h01020304) begin fails++; $display("FAIL b2b_rdata: got %h,%h want %h,01020304", r1, r2, mread(32'h10)); end
    endtask

    task automatic test_random;
        int lat, st; logic ds, er; logic [31:0] rd, a, d, exp;
        logic [3:0] w;
        for (int i = 0; i < 32; i++) begin
            d = $urandom;
            access(4'b1111, 32'h400 + 32'(i * 4), d, lat, st, ds, rd, er);
            mwrite(32'h400 + 32'(i * 4), 4'b1111, d);
        end
        for (int n = 0; n < 60; n++) begin
            a = 32'h400 + 32'($urandom_range(0, 127));
            w = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
            d = $urandom;
            exp = w == 0 ? mread(a) : 32'h0;
            access(w, a, d, lat, st, ds, rd, er);
            mwrite(a, w, d);
            tests++; if (lat !== 3 || st !== 3 || ds !== 1'b0) begin fails++; $display("FAIL rand_timing #%0d: got lat=%0d stalls=%0d want 3 3", n, lat, st); end
            tests++; if (rd !== exp || er !== 1'b0) begin fails++; $display("FAIL rand_data #%0d addr=%h wen=%b: got %h err=%b want %h 0", n, a, w, rd, er, exp); end
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_zero_wait;
        test_reset_mid;
        test_range;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far end of the CPU's M-stage load/store interface. Accepts a word-aligned access (byte-lane enables, lane-aligned write data), performs it against an on-chip word-organised RAM after a configurable number of wait states, and drives a stall back to the pipeline until the access completes. Sits between the pipeline's memory stage and the data RAM, in place of a zero-latency memory model.

## Interface
- `ADDR_W`, 12: word-address bits; the RAM holds 2^ADDR_W 32-bit words.
- `WAIT_CYC`, 2: extra wait cycles per access, legal range 0..15.

- `clk`, in, 1: clock.
- `rst`, in, 1: reset; one clock, synchronous, active-high.
- `req`, in, 1: access request from the M stage.
- `wen`, in, 4: byte-lane write enables (bit i = byte i). 4'b0000 = read.
- `addr`, in, 32: byte address. Bits [1:0] ignored; word index = addr[ADDR_W+1:2].
- `wdata`, in, 32: lane-aligned write data.
- `rdata`, out, 32: read data. Valid only in the `done` cycle.
- `stall`, out, 1: M-stage hold request.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: range-error pulse, coincident with `done`. Tied 0 without the macro.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait states.
  - RESP: completion cycle.
- Transitions:
  - IDLE & req: latch wen/addr/wdata, load the wait counter with WAIT_CYC. Go to WAIT if WAIT_CYC>0, else RESP.
  - WAIT: decrement the counter each cycle. When it reaches 1, go to RESP.
  - RESP: always return to IDLE. No request is accepted in RESP.
- RAM access happens on the clock edge that enters RESP, using the latched fields:
  - Write: only lanes with wen[i]=1 are updated.
  - Read: `rdata` is registered on the same edge.
  - The latched wen selects the operation. For a write, `rdata` is 0.
- `stall` is combinational: (IDLE & req) | WAIT. It is 0 in RESP, so the pipeline advances at the end of the `done` cycle.
- The CPU holds req/wen/addr/wdata stable while `stall`=1. Inputs in RESP are ignored.
- Back-to-back requests: the next request is seen in the IDLE cycle after RESP, giving one stalled acceptance cycle.
- RAM contents are not reset.

## Timing
- An access accepted in cycle 0 gives:
  - `stall`=1 in cycles 0..WAIT_CYC.
  - `done`=1 in cycle WAIT_CYC+1.
- Total access time is WAIT_CYC+2 cycles.
- Reset values:
  - state=IDLE, counter=0.
  - rdata=0, done=0, err=0.
  - `stall` forced 0 while rst=1.
- Reset mid-access (IDLE or WAIT with a latched request): the access is dropped and the RAM is unmodified.
- Reset in the cycle entering RESP: reset wins, so no write and no `done`.
- A `req` in the first cycle after reset is accepted normally.

## Configuration
- `DMEM_RANGE_CHECK_EN` defined: an access with addr[31:ADDR_W+2] ≠ 0 is out of range. It still takes the full latency, and in RESP:
  - no RAM write happens;
  - rdata=0;
  - err=1 for one cycle alongside `done`.
- Not defined: upper address bits are ignored, so accesses alias modulo 2^ADDR_W words, and `err` is constant 0.

## Structure
- Shared package `dmem_pkg`:
  - state encoding: IDLE=2'b00, WAIT=2'b01, RESP=2'b10;
  - 4-bit counter width;
  - lane count constant (4).
- Sub-module `dmem_bank`: 2^ADDR_W x 32 RAM with four byte-lane write enables and a registered read port. The top level holds the FSM, counter, request latch and range check.

## Test plan
- WAIT_CYC=2, write wen=4'b1111, addr=0x10, wdata=0xDEADBEEF -> `stall` high in cycles 0..2, `done` in cycle 3. A later read of 0x10 returns 0xDEADBEEF.
- Write wen=4'b0010, addr=0x10, wdata=0x0000AA00 after the above -> a read of 0x10 returns 0xDEADAAEF. A read of 0x13 returns the same word.
- WAIT_CYC=0, read 0x10 -> `stall` high in cycle 0 only, `done` with rdata=0xDEADBEEF in cycle 1.
- Write 0x12345678 to 0x20 (previously 0), assert `rst` in cycle 1 (WAIT) -> no `done`, outputs reset. A later read of 0x20 returns 0x00000000.
- ADDR_W=12, write 0xCAFEF00D to addr 0x0001_0000:
  - With the macro: err=1 with `done`, word 0 unchanged, a read of the same address gives rdata=0 and err=1.
  - Without the macro: word 0 becomes 0xCAFEF00D, err=0.
- Two reads held back-to-back (0x10 then 0x14) -> first `done` in cycle 3, second accepted in cycle 4 with `stall`=1, second `done` in cycle 7.
